// File: rtl/locate_box_pkg.sv
// Shared constants for the locate_box slice. Grid/coordinate defaults come from
// define.v; fallbacks keep the slice self-contained when that file is absent.
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 8
`endif
`ifndef CORROSION_DX
`define CORROSION_DX 8
`endif
`ifndef CORROSION_DY
`define CORROSION_DY 6
`endif

package locate_box_pkg;
    localparam int MIN_CELLS_W = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic {
        CELL_BG  = 1'b0,
        CELL_OBJ = 1'b1
    } cell_t;
endpackage

// File: rtl/locate_grid_cnt.sv
// Raster cell counter: gx fastest, then gy; frame_end marks the last cell.
module locate_grid_cnt #(
    parameter int P_W = `POSITION_WIDTH,
    parameter int G_W = `CORROSION_DX,
    parameter int G_H = `CORROSION_DY
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           valid,
    output logic [P_W-1:0] gx,
    output logic [P_W-1:0] gy,
    output logic           frame_end
);
    logic row_end;
    logic col_end;

    assign row_end   = (gx == P_W'(G_W - 1));
    assign col_end   = (gy == P_W'(G_H - 1));
    assign frame_end = valid && row_end && col_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gx <= '0;
            gy <= '0;
        end else if (valid) begin
            if (row_end) begin
                gx <= '0;
                gy <= col_end ? '0 : gy + 1'b1;
            end else begin
                gx <= gx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/locate_box.sv
// Per-frame bounding box and object-cell population of the corrosion grid.
// Optional LOCATE_ISOLATE_FILTER_EN counts only horizontally paired cells.
module locate_box
    import locate_box_pkg::*;
#(
    parameter int P_W = `POSITION_WIDTH,
    parameter int G_W = `CORROSION_DX,
    parameter int G_H = `CORROSION_DY,
    parameter int N_W = CNT_W_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   i_valid,
    input  logic                   i_wb,
    input  logic [MIN_CELLS_W-1:0] i_min_cells,
    output logic                   o_valid,
    output logic                   o_found,
    output logic [P_W-1:0]         o_x1,
    output logic [P_W-1:0]         o_x2,
    output logic [P_W-1:0]         o_y1,
    output logic [P_W-1:0]         o_y2,
    output logic [N_W-1:0]         o_cnt
);
    logic [P_W-1:0] gx, gy, cx;
    logic           frame_end;
    logic           hit;

    logic [P_W-1:0] min_x, max_x, min_y, max_y;
    logic [N_W-1:0] cnt;
    logic [P_W-1:0] nx_min_x, nx_max_x, nx_min_y, nx_max_y;
    logic [N_W-1:0] nx_cnt;
    logic           found;

    locate_grid_cnt #(.P_W(P_W), .G_W(G_W), .G_H(G_H)) u_grid (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .valid     (i_valid),
        .gx        (gx),
        .gy        (gy),
        .frame_end (frame_end)
    );

`ifdef LOCATE_ISOLATE_FILTER_EN
    // prev_wb holds the cell to the left; the gx check masks the row wrap.
    logic prev_wb;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   prev_wb <= 1'b0;
        else if (i_valid) prev_wb <= i_wb;
    end
    assign hit = i_valid && (i_wb == CELL_OBJ) && (gx != '0) && prev_wb;
    assign cx  = gx - 1'b1;
`else
    assign hit = i_valid && (i_wb == CELL_OBJ);
    assign cx  = gx;
`endif

    // Accumulator values including the current cell, so the frame-end cell is counted.
    always_comb begin
        nx_min_x = min_x;
        nx_max_x = max_x;
        nx_min_y = min_y;
        nx_max_y = max_y;
        nx_cnt   = cnt;
        if (hit) begin
            if (cx < min_x) nx_min_x = cx;
            if (gx > max_x) nx_max_x = gx;
            if (gy < min_y) nx_min_y = gy;
            if (gy > max_y) nx_max_y = gy;
            if (cnt != '1)  nx_cnt   = cnt + 1'b1;
        end
    end

    assign found = (nx_cnt >= N_W'(i_min_cells)) && (nx_cnt != '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            min_x   <= '1;
            max_x   <= '0;
            min_y   <= '1;
            max_y   <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_found <= 1'b0;
            o_x1    <= '0;
            o_x2    <= '0;
            o_y1    <= '0;
            o_y2    <= '0;
            o_cnt   <= '0;
        end else begin
            o_valid <= frame_end;
            if (frame_end) begin
                min_x   <= '1;
                max_x   <= '0;
                min_y   <= '1;
                max_y   <= '0;
                cnt     <= '0;
                o_found <= found;
                o_x1    <= found ? nx_min_x : '0;
                o_x2    <= found ? nx_max_x : '0;
                o_y1    <= found ? nx_min_y : '0;
                o_y2    <= found ? nx_max_y : '0;
                o_cnt   <= nx_cnt;
            end else if (i_valid) begin
                min_x <= nx_min_x;
                max_x <= nx_max_x;
                min_y <= nx_min_y;
                max_y <= nx_max_y;
                cnt   <= nx_cnt;
            end
        end
    end
endmodule
